// File: rtl/axi_cfg_regfile_if.sv
// AXI4-Lite bus bundle for axi_cfg_regfile.
// Five channels (AW/W/B/AR/R); master and slave modports.
interface axi_cfg_regfile_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awvalid,
    output wdata, wstrb, wvalid,
    output bready,
    output araddr, arvalid,
    output rready,
    input  awready, wready,
    input  bresp, bvalid,
    input  arready,
    input  rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid,
    input  wdata, wstrb, wvalid,
    input  bready,
    input  araddr, arvalid,
    input  rready,
    output awready, wready,
    output bresp, bvalid,
    output arready,
    output rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_cfg_regfile.sv
// AXI4-Lite config regfile: NUM_CTRL RW ctrl regs, NUM_STAT RO status regs.
// Ports: S_AXI_ACLK, Local_Reset (async, active-high), s_axi (slave
// modport), ctrl_regs/ctrl_wr_pulse out, stat_regs in. Define
// AXI_CFG_REGFILE_IRQ_EN to add IRQ_STAT/IRQ_MASK words and irq_events/irq.
module axi_cfg_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 9,
  parameter int NUM_CTRL = 8,
  parameter int NUM_STAT = 4,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] CTRL_RST_VAL = '0
) (
  input  logic S_AXI_ACLK,
  input  logic Local_Reset,
  axi_cfg_regfile_if.slave s_axi,
  output logic [NUM_CTRL*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
  output logic [NUM_CTRL-1:0] ctrl_wr_pulse,
  // one dummy word when NUM_STAT is 0 so the port stays legal
  input  logic [(NUM_STAT>0 ? NUM_STAT : 1)*C_S_AXI_DATA_WIDTH-1:0]
               stat_regs
`ifdef AXI_CFG_REGFILE_IRQ_EN
  ,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] irq_events,
  output logic irq
`endif
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int IW = AW - 2;
  localparam int NB = DW / 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
`ifdef AXI_CFG_REGFILE_IRQ_EN
  localparam int IRQ_STAT_IDX = NUM_CTRL + NUM_STAT;
  localparam int IRQ_MASK_IDX = NUM_CTRL + NUM_STAT + 1;
`endif

  function automatic logic [DW-1:0] lane_merge(
    input logic [DW-1:0] cur,
    input logic [DW-1:0] nxt,
    input logic [NB-1:0] strb
  );
    logic [DW-1:0] r;
    r = cur;
    for (int k = 0; k < NB; k++) begin
      if (strb[k]) r[k*8 +: 8] = nxt[k*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] lane_mask(
    input logic [NB-1:0] strb
  );
    logic [DW-1:0] m;
    m = '0;
    for (int k = 0; k < NB; k++) begin
      if (strb[k]) m[k*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

  // Write channel state
  logic          awready_q;
  logic          wready_q;
  logic          aw_held;
  logic          w_held;
  logic [IW-1:0] aw_idx;
  logic [DW-1:0] w_data;
  logic [NB-1:0] w_strb;
  logic          bvalid_q;
  logic [1:0]    bresp_q;

  // Read channel state
  logic          arready_q;
  logic          rvalid_q;
  logic [1:0]    rresp_q;
  logic [DW-1:0] rdata_q;

  logic [DW-1:0] ctrl_q [NUM_CTRL];

  logic                wr_fire;
  logic [NUM_CTRL-1:0] w_sel;
  logic                w_ok;
  logic [IW-1:0]       ar_idx;
  logic [DW-1:0]       rd_data;
  logic [1:0]          rd_resp;

`ifdef AXI_CFG_REGFILE_IRQ_EN
  logic          w_irqs;
  logic          w_irqm;
  logic [DW-1:0] irq_stat;
  logic [DW-1:0] irq_mask;
  logic [DW-1:0] irq_clr;
`endif

  // byte-offset bits carry no meaning for word registers
  logic unused_ok;
  assign unused_ok = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_out
    assign ctrl_regs[g*DW +: DW] = ctrl_q[g];
  end

  // Commit once both beats are latched; one write in flight at most.
  assign wr_fire = aw_held & w_held & ~bvalid_q;

  always_comb begin
    w_sel = '0;
    w_ok  = 1'b0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (aw_idx == IW'(i)) begin
        w_sel[i] = 1'b1;
        w_ok     = 1'b1;
      end
    end
`ifdef AXI_CFG_REGFILE_IRQ_EN
    w_irqs = (aw_idx == IW'(IRQ_STAT_IDX));
    w_irqm = (aw_idx == IW'(IRQ_MASK_IDX));
    w_ok   = w_ok | w_irqs | w_irqm;
`endif
  end

  assign ar_idx = s_axi.araddr[AW-1:2];

  always_comb begin
    rd_data = '0;
    rd_resp = SLVERR;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (ar_idx == IW'(i)) begin
        rd_data = ctrl_q[i];
        rd_resp = OKAY;
      end
    end
    for (int i = 0; i < NUM_STAT; i++) begin
      if (ar_idx == IW'(NUM_CTRL + i)) begin
        rd_data = stat_regs[i*DW +: DW];
        rd_resp = OKAY;
      end
    end
`ifdef AXI_CFG_REGFILE_IRQ_EN
    if (ar_idx == IW'(IRQ_STAT_IDX)) begin
      rd_data = irq_stat;
      rd_resp = OKAY;
    end
    if (ar_idx == IW'(IRQ_MASK_IDX)) begin
      rd_data = irq_mask;
      rd_resp = OKAY;
    end
`endif
  end

  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_idx    <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      if (s_axi.awvalid && awready_q) begin
        aw_held   <= 1'b1;
        awready_q <= 1'b0;
        aw_idx    <= s_axi.awaddr[AW-1:2];
      end
      if (s_axi.wvalid && wready_q) begin
        w_held   <= 1'b1;
        wready_q <= 1'b0;
        w_data   <= s_axi.wdata;
        w_strb   <= s_axi.wstrb;
      end
      if (wr_fire) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= w_ok ? OKAY : SLVERR;
      end
      // READYs stay low until the response is taken
      if (bvalid_q && s_axi.bready) begin
        bvalid_q  <= 1'b0;
        awready_q <= 1'b1;
        wready_q  <= 1'b1;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        ctrl_q[i] <= CTRL_RST_VAL;
      end
      ctrl_wr_pulse <= '0;
    end else begin
      ctrl_wr_pulse <= wr_fire ? w_sel : '0;
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (wr_fire && w_sel[i]) begin
          ctrl_q[i] <= lane_merge(ctrl_q[i], w_data, w_strb);
        end
      end
    end
  end

  // Read data is captured at the AR handshake, so a same-cycle
  // write to the same register is seen by the next read only.
  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
    end else begin
      if (s_axi.arvalid && arready_q) begin
        arready_q <= 1'b0;
        rvalid_q  <= 1'b1;
        rdata_q   <= rd_data;
        rresp_q   <= rd_resp;
      end
      if (rvalid_q && s_axi.rready) begin
        rvalid_q  <= 1'b0;
        arready_q <= 1'b1;
      end
    end
  end

`ifdef AXI_CFG_REGFILE_IRQ_EN
  always_comb begin
    irq_clr = '0;
    if (wr_fire && w_irqs) irq_clr = w_data & lane_mask(w_strb);
  end

  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      irq_stat <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      // new events override a same-cycle W1C clear
      irq_stat <= (irq_stat & ~irq_clr) | irq_events;
      if (wr_fire && w_irqm) begin
        irq_mask <= lane_merge(irq_mask, w_data, w_strb);
      end
      irq <= |(irq_stat & irq_mask);
    end
  end
`endif

endmodule

// File: tb/tb_axi_cfg_regfile.sv
// Testbench for axi_cfg_regfile: directed cases plus random
// traffic checked against an array-based register model.
module tb_axi_cfg_regfile;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int NC = 8;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_cfg_regfile_if #(.AW(AW), .DW(DW)) bus ();

  logic [NC*DW-1:0] ctrl_regs;
  logic [NC-1:0]    pulse;
  logic [NS*DW-1:0] stat_regs;
`ifdef AXI_CFG_REGFILE_IRQ_EN
  logic [DW-1:0] irq_events;
  logic          irq;
`endif

  axi_cfg_regfile #(
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_CTRL(NC),
    .NUM_STAT(NS),
    .CTRL_RST_VAL('0)
  ) dut (
    .S_AXI_ACLK(clk),
    .Local_Reset(rst),
    .s_axi(bus),
    .ctrl_regs(ctrl_regs),
    .ctrl_wr_pulse(pulse),
    .stat_regs(stat_regs)
`ifdef AXI_CFG_REGFILE_IRQ_EN
    ,
    .irq_events(irq_events),
    .irq(irq)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ctrl_m [NC];
`ifdef AXI_CFG_REGFILE_IRQ_EN
  logic [DW-1:0] istat_m = '0;
  logic [DW-1:0] mask_m = '0;
`endif

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge_m(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] strb);
    logic [31:0] r;
    r = 0;
    for (int k = 0; k < 4; k++) begin
      r = r | ((strb[k] ? ((nw >> (8*k)) & 32'hFF)
                        : ((old >> (8*k)) & 32'hFF)) << (8*k));
    end
    return r;
  endfunction

  function automatic logic [NC*DW-1:0] flat_m();
    logic [NC*DW-1:0] f;
    for (int i = 0; i < NC; i++) f[i*DW +: DW] = ctrl_m[i];
    return f;
  endfunction

  // Expected response and side effects of a write, from the map rules
  task automatic model_write(input int idx, input logic [31:0] d,
                             input logic [3:0] s,
                             output logic [1:0] resp,
                             output logic [NC-1:0] pe);
    pe = '0;
    resp = 2'b10;
    if (idx < NC) begin
      ctrl_m[idx] = merge_m(ctrl_m[idx], d, s);
      pe[idx] = 1'b1;
      resp = 2'b00;
    end
`ifdef AXI_CFG_REGFILE_IRQ_EN
    else if (idx == NC + NS) begin
      istat_m = istat_m & ~merge_m(32'h0, d, s);
      resp = 2'b00;
    end else if (idx == NC + NS + 1) begin
      mask_m = merge_m(mask_m, d, s);
      resp = 2'b00;
    end
`endif
  endtask

  function automatic logic [31:0] exp_rdata(input int idx);
    if (idx < NC) return ctrl_m[idx];
    if (idx < NC + NS) return stat_regs[(idx-NC)*DW +: DW];
`ifdef AXI_CFG_REGFILE_IRQ_EN
    if (idx == NC + NS) return istat_m;
    if (idx == NC + NS + 1) return mask_m;
`endif
    return 32'h0;
  endfunction

  function automatic logic [1:0] exp_rresp(input int idx);
    if (idx < NC + NS) return 2'b00;
`ifdef AXI_CFG_REGFILE_IRQ_EN
    if (idx == NC + NS || idx == NC + NS + 1) return 2'b00;
`endif
    return 2'b10;
  endfunction

  task automatic bus_write(input logic [AW-1:0] addr,
                           input logic [31:0] d,
                           input logic [3:0] s,
                           output logic [1:0] resp,
                           output logic [NC-1:0] p_at,
                           output logic [NC-1:0] p_after);
    logic a_ok, w_ok, a, w;
    int n;
    a_ok = 0; w_ok = 0; n = 0;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    while (!(a_ok && w_ok) && n < 20) begin
      a = bus.awvalid & bus.awready;
      w = bus.wvalid & bus.wready;
      @(posedge clk); #1; n++;
      if (a) begin a_ok = 1; bus.awvalid = 1'b0; end
      if (w) begin w_ok = 1; bus.wvalid = 1'b0; end
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("wr_handshake", {a_ok, w_ok, bus.bvalid}, 3'b111);
    resp = bus.bresp;
    p_at = pulse;
    @(posedge clk); #1;
    p_after = pulse;
  endtask

  task automatic bus_read(input logic [AW-1:0] addr,
                          output logic [31:0] d,
                          output logic [1:0] resp);
    logic a_ok, a;
    int n;
    a_ok = 0; n = 0;
    bus.araddr = addr; bus.arvalid = 1'b1;
    while (!a_ok && n < 20) begin
      a = bus.arvalid & bus.arready;
      @(posedge clk); #1; n++;
      if (a) begin a_ok = 1; bus.arvalid = 1'b0; end
    end
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("rd_handshake", {a_ok, bus.rvalid}, 2'b11);
    d = bus.rdata;
    resp = bus.rresp;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0]    resp, eresp;
    logic [NC-1:0] p_at, p_after, pe;
    logic [31:0]   d, old, wd;
    logic [3:0]    ws;
    logic [6:0]    idx7;
    int            bcnt, bfirst, n, idx;

    for (int i = 0; i < NC; i++) ctrl_m[i] = '0;
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    stat_regs = {$urandom, $urandom, $urandom, $urandom};
`ifdef AXI_CFG_REGFILE_IRQ_EN
    irq_events = '0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    chk("rst_valid", {bus.bvalid, bus.rvalid}, 2'b00);
    chk("rst_resp", {bus.bresp, bus.rresp}, 4'b0000);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_ctrl", ctrl_regs, '0);
    chk("rst_pulse", pulse, '0);

    // Full-word write to idx0
    model_write(0, 32'hA5A55A5A, 4'hF, eresp, pe);
    bus_write(9'h000, 32'hA5A55A5A, 4'hF, resp, p_at, p_after);
    chk("w0_bresp", resp, 2'b00);
    chk("w0_pulse", p_at, 8'h01);
    chk("w0_pulse_end", p_after, 8'h00);
    bus_read(9'h000, d, resp);
    chk("r0_data", d, 32'hA5A55A5A);
    chk("r0_rresp", resp, 2'b00);

    // Single byte lane write to idx1
    model_write(1, 32'h12345678, 4'h2, eresp, pe);
    bus_write(9'h004, 32'h12345678, 4'h2, resp, p_at, p_after);
    bus_read(9'h004, d, resp);
    chk("r1_lane", d, 32'h00005600);

    // WSTRB=0: OKAY and pulse, no data change
    model_write(5, 32'hFFFFFFFF, 4'h0, eresp, pe);
    bus_write(9'h014, 32'hFFFFFFFF, 4'h0, resp, p_at, p_after);
    chk("ws0_bresp", resp, 2'b00);
    chk("ws0_pulse", p_at, 8'h20);
    chk("ws0_ctrl", ctrl_regs, flat_m());

    // AW three cycles ahead of W
    wd = $urandom;
    model_write(3, wd, 4'hF, eresp, pe);
    bus.awaddr = 9'h00C; bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bcnt = 0;
    repeat (2) begin
      if (bus.bvalid) bcnt++;
      @(posedge clk); #1;
    end
    chk("awfirst_awready", bus.awready, 1'b0);
    bus.wdata = wd; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    bfirst = -1;
    for (int c = 0; c < 8; c++) begin
      if (bus.bvalid) begin
        bcnt++;
        if (bfirst < 0) bfirst = c;
        chk("awfirst_pulse", pulse, 8'h08);
      end
      @(posedge clk); #1;
    end
    chk("awfirst_bcnt", bcnt, 1);
    chk("awfirst_lat", bfirst, 1);
    chk("awfirst_ctrl", ctrl_regs, flat_m());

    // Write to status register and read unmapped index
    model_write(NC, 32'hDEADBEEF, 4'hF, eresp, pe);
    bus_write(9'(NC * 4), 32'hDEADBEEF, 4'hF, resp, p_at, p_after);
    chk("wstat_bresp", resp, 2'b10);
    chk("wstat_pulse", p_at, '0);
    chk("wstat_ctrl", ctrl_regs, flat_m());
    bus_read(9'h1FC, d, resp);
    chk("r127_rresp", resp, 2'b10);
    chk("r127_rdata", d, 32'h0);
    bus_read(9'(9 * 4), d, resp);
    chk("rstat_data", d, stat_regs[1*DW +: DW]);

    // RREADY held low while stat_regs changes
    bus.rready = 1'b0;
    old = stat_regs[0 +: DW];
    bus.araddr = 9'(NC * 4); bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    chk("stall_rvalid", bus.rvalid, 1'b1);
    for (int c = 0; c < 5; c++) begin
      stat_regs = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk("stall_rdata", {bus.rvalid, bus.arready, bus.rdata},
          {1'b1, 1'b0, old});
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    chk("stall_done", {bus.rvalid, bus.arready}, 2'b01);

    // Same-cycle read and write of ctrl idx2
    old = ctrl_m[2];
    wd = $urandom;
    model_write(2, wd, 4'hF, eresp, pe);
    bus.awaddr = 9'h008; bus.awvalid = 1'b1;
    bus.wdata = wd; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 9'h008; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    chk("rw_same_old", {bus.rvalid, bus.rdata}, {1'b1, old});
    n = 0;
    while (!bus.bvalid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("rw_same_b", {bus.bvalid, bus.bresp}, 3'b100);
    @(posedge clk); #1;
    chk("rw_same_ctrl", ctrl_regs, flat_m());

    // Reset with an address beat pending
    bus.awaddr = 9'h010; bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NC; i++) ctrl_m[i] = '0;
    chk("mid_rst_ctrl", ctrl_regs, '0);
    chk("mid_rst_state", {bus.bvalid, bus.rvalid, bus.awready}, 3'b001);
    @(posedge clk); #1 rst = 1'b0;
    wd = $urandom;
    bus.wdata = wd; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    bcnt = 0;
    repeat (4) begin
      if (bus.bvalid) bcnt++;
      @(posedge clk); #1;
    end
    chk("mid_rst_dropped", bcnt, 0);
    model_write(4, wd, 4'hF, eresp, pe);
    bus.awaddr = 9'h010; bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("mid_rst_b", {bus.bvalid, bus.bresp, pulse}, {3'b100, pe});
    @(posedge clk); #1;
    chk("mid_rst_ctrl2", ctrl_regs, flat_m());

    // Random traffic
    for (int it = 0; it < 60; it++) begin
      stat_regs = {$urandom, $urandom, $urandom, $urandom};
      idx = ($urandom_range(0, 7) == 0) ? 127 : $urandom_range(0, 15);
      idx7 = 7'(idx);
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        ws = 4'($urandom);
        model_write(idx, wd, ws, eresp, pe);
        bus_write({idx7, 2'($urandom)}, wd, ws, resp, p_at, p_after);
        chk("rnd_bresp", resp, eresp);
        chk("rnd_pulse", {p_at, p_after}, {pe, 8'h00});
        chk("rnd_ctrl", ctrl_regs, flat_m());
      end else begin
        bus_read({idx7, 2'($urandom)}, d, resp);
        chk("rnd_rresp", resp, exp_rresp(idx));
        chk("rnd_rdata", d, exp_rdata(idx));
      end
    end

`ifdef AXI_CFG_REGFILE_IRQ_EN
    // Masked event raises irq; W1C clears it
    model_write(NC + NS + 1, 32'h1, 4'hF, eresp, pe);
    bus_write(9'((NC + NS + 1) * 4), 32'h1, 4'hF, resp, p_at, p_after);
    chk("irq_mask_bresp", resp, 2'b00);
    irq_events = 32'h1;
    @(posedge clk); #1;
    irq_events = '0;
    istat_m = istat_m | 32'h1;
    @(posedge clk); #1;
    chk("irq_set", irq, 1'b1);
    bus_read(9'((NC + NS) * 4), d, resp);
    chk("irq_stat_rd", d, istat_m);
    model_write(NC + NS, 32'h1, 4'hF, eresp, pe);
    bus_write(9'((NC + NS) * 4), 32'h1, 4'hF, resp, p_at, p_after);
    @(posedge clk); #1;
    chk("irq_clr", irq, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
